// File: rtl/sqrt_csel_adder_pipe.sv
// sqrt_csel_adder_pipe: pipelined square-root carry-select adder/subtractor.
// Groups are sized 2,2,3,4,5,... from the LSB, and the last group is truncated to WIDTH.
// Group 0 is a ripple adder. Every other group precomputes {sum,carry} for carry-in 0 and 1.
// A select chain then picks each group's pair from the carry out of the group below.
// Stages: S1 operand register, optional mid register (PIPE_MID), output register.
// Every stage uses a valid/ready handshake with back-pressure.
// Optional feature macro: SQRT_CSEL_OVF_EN adds the registered two's-complement overflow output 'ovf'.
module sqrt_csel_adder_pipe #(
  parameter int WIDTH    = 16,
  parameter int PIPE_MID = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SQRT_CSEL_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Nominal size of group g: the first two groups are 2 bits wide, and group g (g >= 2) is g+1 bits wide.
  function automatic int groupSize(input int g);
    return (g < 2) ? 2 : g + 1;
  endfunction

  function automatic int groupStart(input int g);
    int s;
    s = 0;
    for (int i = 0; i < g; i++) s += groupSize(i);
    return s;
  endfunction

  // One past the MSB of group g, truncated to the operand width.
  function automatic int groupEnd(input int g);
    int e;
    e = groupStart(g) + groupSize(g);
    return (e > WIDTH) ? WIDTH : e;
  endfunction

  function automatic int groupCount();
    int n;
    n = 0;
    for (int g = 0; g < WIDTH; g++)
      if (groupStart(g) < WIDTH) n = g + 1;
    return n;
  endfunction

  localparam int NG  = groupCount();
  localparam int G0W = 2;

  logic             s1ValidQ, s1ValidD;
  logic [WIDTH-1:0] aQ, bEffQ;
  logic             cinQ;

  logic             midValidQ;
  logic             outValidQ;
  logic [WIDTH-1:0] sumQ, sumD;
  logic             cOutQ, cOutD;

  logic             outFree, midFree, s1Next, stgValid;

  logic [WIDTH-1:0]   preSum0;
  logic [WIDTH-1:G0W] preSum1;
  logic [NG-1:0]      preC0;
  logic [NG-1:1]      preC1;

  logic [WIDTH-1:0]   stgSum0;
  logic [WIDTH-1:G0W] stgSum1;
  logic [NG-1:0]      stgC0;
  logic [NG-1:1]      stgC1;

`ifdef SQRT_CSEL_OVF_EN
  logic preMsbXor, stgMsbXor;
  logic ovfQ, ovfD;
`endif

  // Handshake: a stage may take new data when it is empty or its current contents move on.
  always_comb begin
    outFree  = !outValidQ || out_ready;
    midFree  = !midValidQ || outFree;
    s1Next   = (PIPE_MID != 0) ? midFree : outFree;
    stgValid = (PIPE_MID != 0) ? midValidQ : s1ValidQ;
    in_ready = !s1ValidQ || s1Next;
    s1ValidD = (in_valid && in_ready) || (s1ValidQ && !s1Next);
  end

  // S1 stores operand A, the effective B (inverted when subtracting) and the effective carry-in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1ValidQ <= 1'b0;
      aQ       <= '0;
      bEffQ    <= '0;
      cinQ     <= 1'b0;
    end else begin
      s1ValidQ <= s1ValidD;
      if (in_valid && in_ready) begin
        aQ    <= a;
        bEffQ <= sub ? ~b : b;
        cinQ  <= sub | c_in;
      end
    end
  end

  // Group precompute: ripple group 0 on the real carry-in, and compute both carry-in cases for the other groups.
  always_comb begin
    logic c0;
    logic c1;
    preSum0 = '0;
    preSum1 = '0;
    preC0   = '0;
    preC1   = '0;
    c0 = cinQ;
    for (int i = 0; i < G0W; i++) begin
      preSum0[i] = aQ[i] ^ bEffQ[i] ^ c0;
      c0 = (aQ[i] & bEffQ[i]) | (c0 & (aQ[i] ^ bEffQ[i]));
    end
    preC0[0] = c0;
    for (int g = 1; g < NG; g++) begin
      c0 = 1'b0;
      c1 = 1'b1;
      for (int i = groupStart(g); i < groupEnd(g); i++) begin
        preSum0[i] = aQ[i] ^ bEffQ[i] ^ c0;
        preSum1[i] = aQ[i] ^ bEffQ[i] ^ c1;
        c0 = (aQ[i] & bEffQ[i]) | (c0 & (aQ[i] ^ bEffQ[i]));
        c1 = (aQ[i] & bEffQ[i]) | (c1 & (aQ[i] ^ bEffQ[i]));
      end
      preC0[g] = c0;
      preC1[g] = c1;
    end
  end

`ifdef SQRT_CSEL_OVF_EN
  assign preMsbXor = aQ[WIDTH-1] ^ bEffQ[WIDTH-1];
`endif

  if (PIPE_MID != 0) begin : g_mid
    logic [WIDTH-1:0]   midSum0Q;
    logic [WIDTH-1:G0W] midSum1Q;
    logic [NG-1:0]      midC0Q;
    logic [NG-1:1]      midC1Q;
`ifdef SQRT_CSEL_OVF_EN
    logic               midMsbXorQ;
`endif

    // Mid register holds the candidate pairs so the select chain runs in its own cycle.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        midValidQ  <= 1'b0;
        midSum0Q   <= '0;
        midSum1Q   <= '0;
        midC0Q     <= '0;
        midC1Q     <= '0;
`ifdef SQRT_CSEL_OVF_EN
        midMsbXorQ <= 1'b0;
`endif
      end else if (midFree) begin
        midValidQ <= s1ValidQ;
        if (s1ValidQ) begin
          midSum0Q   <= preSum0;
          midSum1Q   <= preSum1;
          midC0Q     <= preC0;
          midC1Q     <= preC1;
`ifdef SQRT_CSEL_OVF_EN
          midMsbXorQ <= preMsbXor;
`endif
        end
      end
    end

    assign stgSum0   = midSum0Q;
    assign stgSum1   = midSum1Q;
    assign stgC0     = midC0Q;
    assign stgC1     = midC1Q;
`ifdef SQRT_CSEL_OVF_EN
    assign stgMsbXor = midMsbXorQ;
`endif
  end else begin : g_nomid
    assign midValidQ = 1'b0;
    assign stgSum0   = preSum0;
    assign stgSum1   = preSum1;
    assign stgC0     = preC0;
    assign stgC1     = preC1;
`ifdef SQRT_CSEL_OVF_EN
    assign stgMsbXor = preMsbXor;
`endif
  end

  // Select chain: each group's carry-in picks its candidate pair, and the chosen carry feeds the next group.
  always_comb begin
    logic carry;
    sumD  = stgSum0;
    carry = stgC0[0];
    for (int g = 1; g < NG; g++) begin
      for (int i = groupStart(g); i < groupEnd(g); i++)
        if (carry) sumD[i] = stgSum1[i];
      carry = carry ? stgC1[g] : stgC0[g];
    end
    cOutD = carry;
  end

`ifdef SQRT_CSEL_OVF_EN
  assign ovfD = (stgMsbXor ^ sumD[WIDTH-1]) ^ cOutD;
`endif

  // Output register holds the result stable until the consumer accepts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValidQ <= 1'b0;
      sumQ      <= '0;
      cOutQ     <= 1'b0;
`ifdef SQRT_CSEL_OVF_EN
      ovfQ      <= 1'b0;
`endif
    end else if (outFree) begin
      outValidQ <= stgValid;
      if (stgValid) begin
        sumQ  <= sumD;
        cOutQ <= cOutD;
`ifdef SQRT_CSEL_OVF_EN
        ovfQ  <= ovfD;
`endif
      end
    end
  end

  assign out_valid = outValidQ;
  assign sum       = sumQ;
  assign c_out     = cOutQ;
`ifdef SQRT_CSEL_OVF_EN
  assign ovf       = ovfQ;
`endif

endmodule
